// File: rtl/sobel_frame_scheduler.sv
// sobel_frame_scheduler: control FSM for a single Sobel frame.
// It receives IMG_W*IMG_H pixel bytes into the framebuffer, runs the Sobel
// engine on each interior pixel in raster order, hands each result to the
// transmitter, and then pulses done.
// Optional feature: define SOBEL_SCHED_TIMEOUT_EN to add a watchdog on the
// WAIT_CALC/WAIT_TX handshakes and an ERROR state that it can enter.
module sobel_frame_scheduler #(
  parameter int IMG_W          = 16,
  parameter int IMG_H          = 16,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              rx_pronto,
  output logic              rx_enable,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              sobel_calcula,
  input  logic              sobel_pronto,
  output logic              tx_partida,
  output logic              tx_enable,
  input  logic              tx_pronto,
  output logic              clean_counters,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [3:0]        db_estado
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

  localparam logic [CNT_W-1:0]  NPIX      = CNT_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 3);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_H - 3);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLEAR     = 4'd1,
    S_RECEIVE   = 4'd2,
    S_CALC      = 4'd3,
    S_WAIT_CALC = 4'd4,
    S_SEND      = 4'd5,
    S_WAIT_TX   = 4'd6,
    S_DONE      = 4'd7
`ifdef SOBEL_SCHED_TIMEOUT_EN
    ,
    S_ERROR     = 4'd8
`endif
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   rx_count;
  logic [CNT_W-1:0]   rx_count_n;
  // Interior position, stored as an offset from pixel (1,1).
  logic [CW-1:0]      col;
  logic [CW-1:0]      col_n;
  logic [RW-1:0]      row;
  logic [RW-1:0]      row_n;
  logic               abort_seen;
  logic               wr_accept;
  logic               last_pix;
  logic [ADDR_W-1:0]  pix_addr;

`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_count;
  logic            timeout_hit;

  assign timeout_hit = (wd_count == WD_LAST);

  // Watchdog: counts consecutive cycles spent in one handshake-wait state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_count <= '0;
    end else if ((state == S_WAIT_CALC && state_n == S_WAIT_CALC) ||
                 (state == S_WAIT_TX   && state_n == S_WAIT_TX)) begin
      wd_count <= wd_count + 1'b1;
    end else begin
      wd_count <= '0;
    end
  end
`endif

  assign db_estado = state;

  // Next-state, counter updates and next interior address.
  always_comb begin
    state_n    = state;
    rx_count_n = rx_count;
    col_n      = col;
    row_n      = row;
    wr_accept  = (state == S_RECEIVE) && rx_pronto && !abort && (rx_count < NPIX);
    last_pix   = (col == COL_LAST) && (row == ROW_LAST);

    if (abort && state != S_IDLE) begin
      state_n = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:      if (start) state_n = S_CLEAR;
        S_CLEAR:     state_n = abort_seen ? S_IDLE : S_RECEIVE;
        // fb_we/fb_addr show the write issued this cycle, so the final
        // address being written marks the end of reception.
        S_RECEIVE:   if (fb_we && fb_addr == LAST_ADDR) state_n = S_CALC;
        S_CALC:      state_n = S_WAIT_CALC;
        S_WAIT_CALC: begin
          if (sobel_pronto) state_n = S_SEND;
`ifdef SOBEL_SCHED_TIMEOUT_EN
          else if (timeout_hit) state_n = S_ERROR;
`endif
        end
        S_SEND:      state_n = S_WAIT_TX;
        S_WAIT_TX: begin
          if (tx_pronto) begin
            if (last_pix) begin
              state_n = S_DONE;
            end else begin
              state_n = S_CALC;
              if (col == COL_LAST) begin
                col_n = '0;
                row_n = row + 1'b1;
              end else begin
                col_n = col + 1'b1;
              end
            end
          end
`ifdef SOBEL_SCHED_TIMEOUT_EN
          else if (timeout_hit) state_n = S_ERROR;
`endif
        end
        S_DONE:      state_n = S_IDLE;
`ifdef SOBEL_SCHED_TIMEOUT_EN
        S_ERROR:     if (start) state_n = S_CLEAR;
`endif
        default:     state_n = S_IDLE;
      endcase
    end

    if (wr_accept) rx_count_n = rx_count + 1'b1;

    if (state_n == S_CLEAR) begin
      rx_count_n = '0;
      col_n      = '0;
      row_n      = '0;
    end

    pix_addr = ADDR_W'((int'(row_n) + 1) * IMG_W + int'(col_n) + 1);
  end

  // State, counters and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      rx_count       <= '0;
      col            <= '0;
      row            <= '0;
      abort_seen     <= 1'b0;
      rx_enable      <= 1'b0;
      fb_we          <= 1'b0;
      fb_addr        <= '0;
      sobel_calcula  <= 1'b0;
      tx_partida     <= 1'b0;
      tx_enable      <= 1'b0;
      clean_counters <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      rx_count       <= rx_count_n;
      col            <= col_n;
      row            <= row_n;
      if (state_n == S_CLEAR) abort_seen <= abort && (state != S_IDLE);
      rx_enable      <= (state_n == S_RECEIVE);
      fb_we          <= wr_accept;
      if (wr_accept)                fb_addr <= rx_count[ADDR_W-1:0];
      else if (state_n == S_CALC)   fb_addr <= pix_addr;
      else if (state_n == S_CLEAR)  fb_addr <= '0;
      sobel_calcula  <= (state_n == S_CALC);
      tx_partida     <= (state_n == S_SEND);
      tx_enable      <= (state_n == S_SEND) || (state_n == S_WAIT_TX);
      clean_counters <= (state_n == S_CLEAR);
      done           <= (state_n == S_DONE);
`ifdef SOBEL_SCHED_TIMEOUT_EN
      busy           <= (state_n != S_IDLE) && (state_n != S_ERROR);
`else
      busy           <= (state_n != S_IDLE);
`endif
    end
  end

`ifdef SOBEL_SCHED_TIMEOUT_EN
  // Error flag: set on entering ERROR, cleared when ERROR is left.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) erro <= 1'b0;
    else        erro <= (state_n == S_ERROR);
  end
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for sobel_frame_scheduler on a 4x4 image.
// The timeout scenario is only exercised when SOBEL_SCHED_TIMEOUT_EN is defined.
module tb_sobel_frame_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       rx_pronto = 1'b0;
  logic       sobel_pronto = 1'b0;
  logic       tx_pronto = 1'b0;
  logic       rx_enable, fb_we, sobel_calcula, tx_partida, tx_enable;
  logic       clean_counters, busy, done, erro;
  logic [3:0] fb_addr;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_errors = 0;
  int calc_cnt = 0;
  int tx_cnt   = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;

  sobel_frame_scheduler #(
    .IMG_W(4),
    .IMG_H(4),
    .ADDR_W(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .rx_pronto(rx_pronto),
    .rx_enable(rx_enable),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .sobel_calcula(sobel_calcula),
    .sobel_pronto(sobel_pronto),
    .tx_partida(tx_partida),
    .tx_enable(tx_enable),
    .tx_pronto(tx_pronto),
    .clean_counters(clean_counters),
    .busy(busy),
    .done(done),
    .erro(erro),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters, sampled away from the rising edge.
  always @(negedge clock) begin
    if (reset) begin
      if (sobel_calcula) calc_cnt <= calc_cnt + 1;
      if (tx_partida)    tx_cnt   <= tx_cnt + 1;
      if (done)          done_cnt <= done_cnt + 1;
      if (fb_we)         wr_cnt   <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, rx_enable, fb_we, fb_addr, sobel_calcula, tx_partida, tx_enable,
            clean_counters, busy, done, erro, db_estado};
  endfunction

  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clear_state", db_estado, 4'd1);
    check("start_clean_counters", clean_counters, 1'b1);
    step();
    check("start_receive_state", db_estado, 4'd2);
    check("start_rx_enable", rx_enable, 1'b1);
  endtask

  int base_calc, base_tx, base_done, base_wr;
  logic [3:0] exp_pix [4] = '{4'd5, 4'd6, 4'd9, 4'd10};

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset then idle.
    #1;
    check("reset_outputs_during", all_outs(), 32'd0);
    repeat (3) step();
    check("reset_outputs_held", all_outs(), 32'd0);
    reset = 1'b1;
    step();
    check("idle_outputs_after_release", all_outs(), 32'd0);
    step();
    check("idle_state", db_estado, 4'd0);
    check("idle_busy", busy, 1'b0);

    // Full 4x4 frame.
    base_calc = calc_cnt; base_tx = tx_cnt; base_done = done_cnt; base_wr = wr_cnt;
    start_frame();
    check("frame_busy", busy, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i >= 8) begin
        rx_pronto = 1'b0;
        if (i == 10) tx_pronto = 1'b1;
        step();
        tx_pronto = 1'b0;
        check("gap_no_write", fb_we, 1'b0);
        check("gap_state_receive", db_estado, 4'd2);
      end
      rx_pronto = 1'b1;
      step();
      check("wr_strobe", fb_we, 1'b1);
      check("wr_addr", fb_addr, i[3:0]);
    end
    rx_pronto = 1'b0;
    step();
    for (int p = 0; p < 4; p++) begin
      check("calc_state", db_estado, 4'd3);
      check("calc_pulse", sobel_calcula, 1'b1);
      check("calc_addr", fb_addr, exp_pix[p]);
      step();
      check("wait_calc_state", db_estado, 4'd4);
      check("wait_calc_addr_hold", fb_addr, exp_pix[p]);
      check("wait_calc_pulse_low", sobel_calcula, 1'b0);
      step();
      step();
      sobel_pronto = 1'b1;
      step();
      sobel_pronto = 1'b0;
      check("send_state", db_estado, 4'd5);
      check("send_partida", tx_partida, 1'b1);
      check("send_tx_enable", tx_enable, 1'b1);
      step();
      check("wait_tx_state", db_estado, 4'd6);
      check("wait_tx_partida_low", tx_partida, 1'b0);
      check("wait_tx_enable", tx_enable, 1'b1);
      if (p == 0) begin
        sobel_pronto = 1'b1;
        step();
        sobel_pronto = 1'b0;
        check("spurious_sobel_state", db_estado, 4'd6);
        check("spurious_sobel_no_partida", tx_partida, 1'b0);
        repeat (7) step();
      end else begin
        repeat (8) step();
      end
      tx_pronto = 1'b1;
      step();
      tx_pronto = 1'b0;
      check("after_tx_enable_low", tx_enable, 1'b0);
    end
    check("done_state", db_estado, 4'd7);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b1);
    step();
    check("post_done_state", db_estado, 4'd0);
    check("post_done_pulse_low", done, 1'b0);
    check("post_done_busy", busy, 1'b0);
    check("frame_erro", erro, 1'b0);
    check("frame_write_count", wr_cnt - base_wr, 32'd16);
    check("frame_calc_count", calc_cnt - base_calc, 32'd4);
    check("frame_tx_count", tx_cnt - base_tx, 32'd4);
    check("frame_done_count", done_cnt - base_done, 32'd1);

    // Abort mid-RECEIVE after byte 7.
    start_frame();
    rx_pronto = 1'b1;
    repeat (8) step();
    rx_pronto = 1'b0;
    check("abort_last_addr", fb_addr, 4'd7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_clear_state", db_estado, 4'd1);
    check("abort_clean_counters", clean_counters, 1'b1);
    check("abort_no_write", fb_we, 1'b0);
    step();
    check("abort_idle_state", db_estado, 4'd0);
    check("abort_idle_busy", busy, 1'b0);
    check("abort_rx_enable_low", rx_enable, 1'b0);
    start_frame();
    rx_pronto = 1'b1;
    step();
    rx_pronto = 1'b0;
    check("restart_wr_strobe", fb_we, 1'b1);
    check("restart_addr_zero", fb_addr, 4'd0);

    // Reset mid-frame: frame discarded, no done.
    base_done = done_cnt;
    step();
    reset = 1'b0;
    #1;
    check("midreset_outputs", all_outs(), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("midreset_idle_state", db_estado, 4'd0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_no_done", done_cnt - base_done, 32'd0);

`ifdef SOBEL_SCHED_TIMEOUT_EN
    begin
      int n;
      start_frame();
      rx_pronto = 1'b1;
      repeat (16) step();
      rx_pronto = 1'b0;
      step();
      check("to_calc_state", db_estado, 4'd3);
      step();
      check("to_wait_calc_state", db_estado, 4'd4);
      n = 0;
      while (db_estado != 4'd8 && n < 100) begin
        step();
        n++;
      end
      check("to_cycles_to_error", n, 32'd20);
      check("to_error_state", db_estado, 4'd8);
      check("to_erro_flag", erro, 1'b1);
      check("to_error_busy", busy, 1'b0);
      step();
      check("to_erro_sticky", erro, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("to_restart_state", db_estado, 4'd1);
      check("to_restart_erro", erro, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_scheduler.md
SOBEL_FRAME_SCHEDULER -- requirements
Module: sobel_frame_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 16: image width in pixels, at least 3.
REQ-002 SHALL have parameter IMG_H, default 16: image height in pixels, at least 3.
REQ-003 SHALL have parameter ADDR_W, default 8: framebuffer address width; IMG_W*IMG_H SHALL be at most 2^ADDR_W.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000000: watchdog limit, used only when SOBEL_SCHED_TIMEOUT_EN is defined.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: requests processing of one frame; sampled only in IDLE or ERROR.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the frame in progress.
REQ-009 SHALL have ports rx_pronto (input, 1) and rx_enable (output, 1): receiver byte-valid pulse and receiver enable.
REQ-010 SHALL have ports fb_we (output, 1) and fb_addr (output, ADDR_W): framebuffer write strobe and pixel address.
REQ-011 SHALL have ports sobel_calcula (output, 1) and sobel_pronto (input, 1): Sobel start pulse and result-ready pulse.
REQ-012 SHALL have ports tx_partida (output, 1), tx_enable (output, 1) and tx_pronto (input, 1): transmitter start, transmitter enable and transmitter done.
REQ-013 SHALL have port clean_counters, output, 1 bit: clears the datapath framebuffer counters.
REQ-014 SHALL have ports busy (output, 1), done (output, 1), erro (output, 1) and db_estado (output, 4): status flags and state code.

Function
REQ-015 SHALL implement the FSM states IDLE=0, CLEAR=1, RECEIVE=2, CALC=3, WAIT_CALC=4, SEND=5, WAIT_TX=6, DONE=7 and ERROR=8; db_estado SHALL show the current state code.
REQ-016 IDLE SHALL move to CLEAR on start=1.
REQ-017 CLEAR SHALL last exactly 1 cycle with clean_counters=1, zero both counters, then move to RECEIVE.
REQ-018 RECEIVE SHALL hold rx_enable=1; each rx_pronto SHALL give, on the next cycle, fb_we=1 for 1 cycle with fb_addr=rx_count, then increment rx_count.
REQ-019 After the write of address IMG_W*IMG_H-1, the FSM SHALL move to CALC.
REQ-020 Output pixels SHALL be the interior pixels only, row 1..IMG_H-2 and column 1..IMG_W-2, in raster order; the count is (IMG_W-2)*(IMG_H-2).
REQ-021 CALC SHALL last 1 cycle with sobel_calcula=1 and fb_addr=row*IMG_W+col, then move to WAIT_CALC; fb_addr SHALL hold this value through WAIT_CALC.
REQ-022 WAIT_CALC SHALL move to SEND on sobel_pronto=1.
REQ-023 SEND SHALL last 1 cycle with tx_partida=1, then move to WAIT_TX; tx_enable SHALL be 1 in SEND and WAIT_TX.
REQ-024 WAIT_TX, on tx_pronto=1, SHALL move to DONE if this was the last interior pixel; otherwise it SHALL advance the column (wrapping to the next row at IMG_W-2) and move to CALC.
REQ-025 DONE SHALL last 1 cycle with done=1, then move to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE and ERROR.
REQ-027 abort=1 in any state other than IDLE SHALL force CLEAR on the next edge, then IDLE; abort SHALL take priority over every other event.
REQ-028 rx_pronto outside RECEIVE, sobel_pronto outside WAIT_CALC, tx_pronto outside WAIT_TX, and start outside IDLE/ERROR SHALL be ignored.
REQ-029 If rx_pronto arrives while the previous fb_we is still pending, the scheduler SHALL still produce one write per byte, in order.
REQ-030 All outputs SHALL be registered, except db_estado.

Reset
REQ-031 While reset=0, the FSM SHALL be forced to IDLE, both counters SHALL be 0, and every output SHALL be 0, including fb_addr and db_estado.
REQ-032 Reset asserted mid-frame SHALL discard the frame, with no done pulse; the first cycle after release SHALL be IDLE.

Configuration
REQ-033 With SOBEL_SCHED_TIMEOUT_EN defined, a watchdog SHALL count consecutive cycles in WAIT_CALC or WAIT_TX.
REQ-034 When that watchdog reaches TIMEOUT_CYCLES, the FSM SHALL go to ERROR with erro=1; erro SHALL stay 1 until start (ERROR to CLEAR) or reset.
REQ-035 Without SOBEL_SCHED_TIMEOUT_EN, the watchdog and the ERROR state SHALL be absent, and erro SHALL be tied to 0.

Verification
REQ-036 Reset then idle: with reset=0 for 3 cycles then released, all outputs are 0, db_estado=0 and busy=0.
REQ-037 Full 4x4 frame: IMG_W=4, IMG_H=4, start, 16 rx_pronto pulses, each sobel_pronto 3 cycles after sobel_calcula, each tx_pronto 10 cycles after tx_partida -> writes at addresses 0..15, sobel_calcula at fb_addr 5, 6, 9, 10, 4 tx_partida pulses, then one done pulse.
REQ-038 Abort mid-RECEIVE: abort after byte 7 -> CLEAR with clean_counters=1, then IDLE; a later start receives again from address 0.
REQ-039 Spurious handshakes: tx_pronto during RECEIVE and sobel_pronto during WAIT_TX -> no state change and no extra pulses.
REQ-040 Timeout with the macro defined: TIMEOUT_CYCLES=20 and sobel_pronto never asserted -> ERROR (db_estado=8) 20 cycles after entering WAIT_CALC, erro=1; start clears erro and gives db_estado=1.
